reset_sequencer: RTL and testbench



---
 rtl/reset_sequencer.sv | 110 +++++++++++
 tb/tb_reset_sequencer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// reset_sequencer: cold/warm reset generator for NUM_CHANNELS domains.
// Releases active-low domain resets in index order on a fixed stagger.
module reset_sequencer #(
   parameter int NUM_CHANNELS      = 4,
   parameter int COLD_RESET_CYCLES = 10,
   parameter int WARM_RESET_CYCLES = 4,
   parameter int STAGGER_CYCLES    = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    warm_req,
   input  logic [NUM_CHANNELS-1:0] warm_mask,
   output logic [NUM_CHANNELS-1:0] rst_out_n,
   output logic                    ready
);

   localparam int REL_SPAN = (NUM_CHANNELS - 1) * STAGGER_CYCLES + 1;
   localparam int MAX_CW   = (COLD_RESET_CYCLES > WARM_RESET_CYCLES) ?
                             COLD_RESET_CYCLES : WARM_RESET_CYCLES;
   localparam int MAX_ALL  = (MAX_CW > REL_SPAN) ? MAX_CW : REL_SPAN;
   localparam int CW       = $clog2(MAX_ALL) + 1;

   localparam logic [CW-1:0] COLD_LAST = CW'(COLD_RESET_CYCLES - 1);
   localparam logic [CW-1:0] WARM_LAST = CW'(WARM_RESET_CYCLES - 1);
   localparam logic [CW-1:0] REL_LAST  = CW'(REL_SPAN - 1);

   typedef enum logic [1:0] {
      COLD_HOLD,
      WARM_HOLD,
      RELEASE,
      IDLE
   } state_t;

   state_t                  state, state_nxt;
   logic [CW-1:0]           cnt, cnt_nxt;
   logic [NUM_CHANNELS-1:0] act_mask, act_mask_nxt;
   logic [NUM_CHANNELS-1:0] rst_out_n_nxt;
   logic                    ready_nxt;

   // State and output flops; cold reset wins over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= COLD_HOLD;
         cnt       <= '0;
         act_mask  <= '1;
         rst_out_n <= '0;
         ready     <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         act_mask  <= act_mask_nxt;
         rst_out_n <= rst_out_n_nxt;
         ready     <= ready_nxt;
      end
   end

   // Next-state: hold count, staggered sweep, warm-request acceptance.
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      act_mask_nxt  = act_mask;
      rst_out_n_nxt = rst_out_n;
      ready_nxt     = ready;
      unique case (state)
         COLD_HOLD: begin
            if (cnt == COLD_LAST) begin
               state_nxt = RELEASE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         WARM_HOLD: begin
            if (cnt == WARM_LAST) begin
               state_nxt = RELEASE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         RELEASE: begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
               if (act_mask[i] && (cnt == CW'(i * STAGGER_CYCLES)))
                  rst_out_n_nxt[i] = 1'b1;
            end
            if (cnt == REL_LAST) begin
               state_nxt = IDLE;
               ready_nxt = 1'b1;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         IDLE: begin
            if (warm_req && (|warm_mask)) begin
               act_mask_nxt  = warm_mask;
               rst_out_n_nxt = rst_out_n & ~warm_mask;
               ready_nxt     = 1'b0;
               state_nxt     = WARM_HOLD;
               cnt_nxt       = '0;
            end
         end
         default: begin
            state_nxt = COLD_HOLD;
            cnt_nxt   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: scoreboard bench for reset_sequencer.
// Runs the default config plus the N=1 and N=8 stagger-0 corners.
module tb_reset_sequencer;

   localparam int N = 4;
   localparam int C = 10;
   localparam int W = 4;
   localparam int S = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       warm_req = 1'b0;
   logic [3:0] warm_mask = 4'h0;
   logic [3:0] m_out;
   logic       m_rdy;
   logic [0:0] c1_out;
   logic       c1_rdy;
   logic [7:0] c8_out;
   logic       c8_rdy;

   always #5 clk = ~clk;

   reset_sequencer #(
      .NUM_CHANNELS(N), .COLD_RESET_CYCLES(C),
      .WARM_RESET_CYCLES(W), .STAGGER_CYCLES(S)
   ) dut (
      .clk(clk), .rst(rst), .warm_req(warm_req),
      .warm_mask(warm_mask), .rst_out_n(m_out), .ready(m_rdy)
   );

   reset_sequencer #(
      .NUM_CHANNELS(1), .COLD_RESET_CYCLES(1),
      .WARM_RESET_CYCLES(4), .STAGGER_CYCLES(0)
   ) dut_c1 (
      .clk(clk), .rst(rst), .warm_req(1'b0),
      .warm_mask(1'b0), .rst_out_n(c1_out), .ready(c1_rdy)
   );

   reset_sequencer #(
      .NUM_CHANNELS(8), .COLD_RESET_CYCLES(C),
      .WARM_RESET_CYCLES(4), .STAGGER_CYCLES(0)
   ) dut_c8 (
      .clk(clk), .rst(rst), .warm_req(1'b0),
      .warm_mask(8'h00), .rst_out_n(c8_out), .ready(c8_rdy)
   );

   typedef struct packed {
      logic [3:0] m_out;
      logic       m_rdy;
      logic       c1;
      logic [7:0] c8_out;
      logic       c8_rdy;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   fails  = 0;
   int   cyc    = 0;

   // Timing model state, derived from the published edge formulas.
   int         k = 0;
   int         kc = 0;
   int         w = 0;
   bit         in_warm = 1'b0;
   logic [3:0] wmask = 4'h0;
   logic [3:0] x_out = 4'h0;
   logic       x_rdy = 1'b0;

   task automatic chk(input string name, input logic [7:0] act,
                      input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s cycle %0d: got %h expected %h",
                  name, cyc, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic req,
                       input logic [3:0] mask);
      exp_t e;
      rst       = r;
      warm_req  = req;
      warm_mask = mask;
      if (r) begin
         k = 0;
         kc = 0;
         in_warm = 1'b0;
      end else begin
         kc++;
         if (x_rdy && req && (mask != 4'h0)) begin
            in_warm = 1'b1;
            w = 0;
            wmask = mask;
         end else if (in_warm) begin
            w++;
         end else begin
            k++;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (r)
            x_out[i] = 1'b0;
         else if (in_warm)
            x_out[i] = wmask[i] ? (w >= W + 1 + i * S) : 1'b1;
         else
            x_out[i] = (k >= C + 1 + i * S);
      end
      if (r)
         x_rdy = 1'b0;
      else if (in_warm)
         x_rdy = (w >= W + 1 + (N - 1) * S);
      else
         x_rdy = (k >= C + 1 + (N - 1) * S);
      e.m_out  = x_out;
      e.m_rdy  = x_rdy;
      e.c1     = !r && (kc >= 2);
      e.c8_out = (!r && (kc >= C + 1)) ? 8'hff : 8'h00;
      e.c8_rdy = !r && (kc >= C + 1);
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Monitor: pop one expectation per edge, compare away from posedge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            cyc++;
            chk("main_rst_out_n", {4'h0, m_out}, {4'h0, e.m_out});
            chk("main_ready", {7'h0, m_rdy}, {7'h0, e.m_rdy});
            chk("c1_rst_out_n", {7'h0, c1_out}, {7'h0, e.c1});
            chk("c1_ready", {7'h0, c1_rdy}, {7'h0, e.c1});
            chk("c8_rst_out_n", c8_out, e.c8_out);
            chk("c8_ready", {7'h0, c8_rdy}, {7'h0, e.c8_rdy});
         end
      end
   end

   initial begin
      repeat (3) step(1'b1, 1'b0, 4'h0);
      repeat (20) step(1'b0, 1'b0, 4'h0);
      step(1'b0, 1'b1, 4'b1010);
      repeat (14) step(1'b0, 1'b0, 4'h0);
      repeat (3) step(1'b0, 1'b1, 4'b0000);
      repeat (2) step(1'b1, 1'b0, 4'h0);
      repeat (17) step(1'b0, 1'b1, 4'b1111);
      repeat (3) step(1'b0, 1'b0, 4'h0);
      repeat (14) step(1'b0, 1'b1, 4'b0011);
      repeat (14) step(1'b0, 1'b0, 4'h0);
      step(1'b0, 1'b1, 4'b1111);
      repeat (7) step(1'b0, 1'b0, 4'h0);
      repeat (2) step(1'b1, 1'b0, 4'h0);
      repeat (20) step(1'b0, 1'b0, 4'h0);
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

endmodule
